load_store_unit: RTL and testbench

- MEM-stage request sequencer sitting directly upstream of the word-organised data memory.
- Accepts one load/store per handshake from the EX/MEM pipeline register.
- Drives the memory's read/write strobes, word address and write data, then returns load data to MEM/WB.
- Supports byte/halfword/word accesses: sign/zero extension on loads, read-modify-write for sub-word stores.

---
 rtl/lsu_pkg.sv | 96 +++++++++
 rtl/lsu_lane_align.sv | 20 ++
 rtl/load_store_unit.sv | 187 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: size encodings, FSM state type,
// and the lane extract/extend and lane merge helpers.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;  // handled exactly like SZ_WORD

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StRdWait,
        StWr,
        StDone
    } lsu_state_t;

    // True for any access wider than a halfword (word or reserved encoding).
    function automatic logic is_word_size(input logic [1:0] size);
        return (size == SZ_WORD) || (size == SZ_RSVD);
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic res;
        res = 1'b0;
        if (size == SZ_HALF) begin
            res = off[0];
        end else if (is_word_size(size)) begin
            res = (off != 2'b00);
        end
        return res;
    endfunction

    // Clear the offset bits below the access size.
    function automatic logic [1:0] force_align(input logic [1:0] size, input logic [1:0] off);
        logic [1:0] res;
        res = off;
        if (size == SZ_HALF) begin
            res = {off[1], 1'b0};
        end else if (is_word_size(size)) begin
            res = 2'b00;
        end
        return res;
    endfunction

    // Pick the addressed lane out of a little-endian word and extend it.
    function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] off,
                                                 input logic [1:0] size, input logic sext);
        logic [4:0]  sh_b;
        logic [4:0]  sh_h;
        logic [31:0] byte_w;
        logic [31:0] half_w;
        logic [31:0] res;
        sh_b   = {off, 3'b000};
        sh_h   = {off[1], 4'b0000};
        byte_w = word >> sh_b;
        half_w = word >> sh_h;
        case (size)
            SZ_BYTE: res = {{24{sext & byte_w[7]}}, byte_w[7:0]};
            SZ_HALF: res = {{16{sext & half_w[15]}}, half_w[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

    // Insert the low byte/half of wdata into word at the addressed lane.
    function automatic logic [31:0] lane_merge(input logic [31:0] word, input logic [31:0] wdata,
                                               input logic [1:0] off, input logic [1:0] size);
        logic [4:0]  sh_b;
        logic [4:0]  sh_h;
        logic [31:0] mask;
        logic [31:0] ins;
        logic [31:0] res;
        sh_b = {off, 3'b000};
        sh_h = {off[1], 4'b0000};
        case (size)
            SZ_BYTE: begin
                mask = 32'h0000_00FF << sh_b;
                ins  = {24'h0, wdata[7:0]} << sh_b;
                res  = (word & ~mask) | ins;
            end
            SZ_HALF: begin
                mask = 32'h0000_FFFF << sh_h;
                ins  = {16'h0, wdata[15:0]} << sh_h;
                res  = (word & ~mask) | ins;
            end
            default: begin
                mask = 32'hFFFF_FFFF;
                ins  = wdata;
                res  = wdata;
            end
        endcase
        return res;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane handling: load extract/extend and sub-word store merge.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    output logic [31:0] o_ext,
    output logic [31:0] o_merged
);

    // Both results are derived from the same captured memory word.
    always_comb begin
        o_ext    = lane_extract(i_word, i_off, i_size, i_signed);
        o_merged = lane_merge(i_word, i_wdata, i_off, i_size);
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store sequencer in front of a word-organised data memory.
// Optional feature: define LSU_MISALIGN_CHECK_EN to reject misaligned
// half/word requests; otherwise low address bits are forced to alignment.
// All outputs are registered and change together with the state register.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 32,
    localparam int unsigned IDX_W = $clog2(MEM_WORDS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_write_i,
    input  logic [1:0]       req_size_i,
    input  logic             req_signed_i,
    input  logic [31:0]      req_addr_i,
    input  logic [31:0]      req_wdata_i,
    output logic             done_o,
    output logic [31:0]      rdata_o,
    output logic             misalign_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic [IDX_W-1:0] mem_addr_o,
    output logic [31:0]      mem_wdata_o,
    input  logic [31:0]      mem_rdata_i
);

    lsu_state_t       r_state, w_state;
    logic             r_ready, w_ready;
    logic             r_done, w_done;
    logic             r_misalign, w_misalign;
    logic             r_mem_read, w_mem_read;
    logic             r_mem_write, w_mem_write;
    logic [IDX_W-1:0] r_mem_addr, w_mem_addr;
    logic [31:0]      r_mem_wdata, w_mem_wdata;
    logic [31:0]      r_rdata, w_rdata;

    // Latched request fields
    logic             r_write, w_write;
    logic [1:0]       r_size, w_size;
    logic             r_signed, w_signed;
    logic [1:0]       r_off, w_off;
    logic [31:0]      r_wdata, w_wdata;

    logic [1:0]       w_off_eff;
    logic             w_misaligned;
    logic [31:0]      w_ext;
    logic [31:0]      w_merged;
    logic             w_addr_unused;

    // Address bits above the memory index wrap away.
    assign w_addr_unused = ^req_addr_i[31:IDX_W+2];

    lsu_lane_align u_lane_align (
        .i_word   (mem_rdata_i),
        .i_wdata  (r_wdata),
        .i_off    (r_off),
        .i_size   (r_size),
        .i_signed (r_signed),
        .o_ext    (w_ext),
        .o_merged (w_merged)
    );

    // Alignment handling of the incoming request offset.
    always_comb begin
`ifdef LSU_MISALIGN_CHECK_EN
        w_off_eff    = req_addr_i[1:0];
        w_misaligned = is_misaligned(req_size_i, req_addr_i[1:0]);
`else
        w_off_eff    = force_align(req_size_i, req_addr_i[1:0]);
        w_misaligned = 1'b0;
`endif
    end

    // Next-state and next-output logic; pulses default low, data holds.
    always_comb begin
        w_state     = r_state;
        w_done      = 1'b0;
        w_misalign  = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_mem_addr  = r_mem_addr;
        w_mem_wdata = r_mem_wdata;
        w_rdata     = r_rdata;
        w_write     = r_write;
        w_size      = r_size;
        w_signed    = r_signed;
        w_off       = r_off;
        w_wdata     = r_wdata;

        case (r_state)
            StIdle: begin
                if (req_valid_i && r_ready) begin
                    w_write    = req_write_i;
                    w_size     = req_size_i;
                    w_signed   = req_signed_i;
                    w_off      = w_off_eff;
                    w_wdata    = req_wdata_i;
                    w_mem_addr = req_addr_i[IDX_W+1:2];
                    if (w_misaligned) begin
                        w_misalign = 1'b1;
                    end else if (!req_write_i || !is_word_size(req_size_i)) begin
                        w_state    = StRd;
                        w_mem_read = 1'b1;
                    end else begin
                        w_state     = StWr;
                        w_mem_write = 1'b1;
                        w_mem_wdata = req_wdata_i;
                    end
                end
            end
            StRd: begin
                w_state = StRdWait;
            end
            StRdWait: begin
                if (r_write) begin
                    w_state     = StWr;
                    w_mem_write = 1'b1;
                    w_mem_wdata = w_merged;
                end else begin
                    w_state = StDone;
                    w_done  = 1'b1;
                    w_rdata = w_ext;
                end
            end
            StWr: begin
                w_state = StDone;
                w_done  = 1'b1;
            end
            StDone: begin
                w_state = StIdle;
            end
            default: begin
                w_state = StIdle;
            end
        endcase

        w_ready = (w_state == StIdle);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state     <= StIdle;
            r_ready     <= 1'b1;
            r_done      <= 1'b0;
            r_misalign  <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
            r_write     <= 1'b0;
            r_size      <= SZ_BYTE;
            r_signed    <= 1'b0;
            r_off       <= 2'b00;
            r_wdata     <= '0;
        end else begin
            r_state     <= w_state;
            r_ready     <= w_ready;
            r_done      <= w_done;
            r_misalign  <= w_misalign;
            r_mem_read  <= w_mem_read;
            r_mem_write <= w_mem_write;
            r_mem_addr  <= w_mem_addr;
            r_mem_wdata <= w_mem_wdata;
            r_rdata     <= w_rdata;
            r_write     <= w_write;
            r_size      <= w_size;
            r_signed    <= w_signed;
            r_off       <= w_off;
            r_wdata     <= w_wdata;
        end
    end

    assign req_ready_o = r_ready;
    assign done_o      = r_done;
    assign misalign_o  = r_misalign;
    assign mem_read_o  = r_mem_read;
    assign mem_write_o = r_mem_write;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;
    assign rdata_o     = r_rdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a synchronous-read
// word memory model attached to the memory-side ports.
module tb_load_store_unit;

    localparam int unsigned MEM_WORDS = 32;
    localparam int unsigned IDX_W = $clog2(MEM_WORDS);

    logic             clk;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic             req_write;
    logic [1:0]       req_size;
    logic             req_signed;
    logic [31:0]      req_addr;
    logic [31:0]      req_wdata;
    logic             done;
    logic [31:0]      rdata;
    logic             misalign;
    logic             mem_read;
    logic             mem_write;
    logic [IDX_W-1:0] mem_addr;
    logic [31:0]      mem_wdata;
    logic [31:0]      mem_rdata;

    logic [31:0]      mem [MEM_WORDS];

    int n_checks = 0;
    int n_pass   = 0;

    // Per-request observations, cycle numbers counted from the accept edge
    int          rd_cyc, wr_cyc, done_cyc, done_last, mis_cyc;
    int          rd_cnt, wr_cnt, both_cnt;
    logic [31:0] seen_wdata, seen_waddr, seen_raddr, seen_rdata;

    load_store_unit #(
        .MEM_WORDS (MEM_WORDS)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_write_i  (req_write),
        .req_size_i   (req_size),
        .req_signed_i (req_signed),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .done_o       (done),
        .rdata_o      (rdata),
        .misalign_o   (misalign),
        .mem_read_o   (mem_read),
        .mem_write_o  (mem_write),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_rdata_i  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: write on strobe, read data registered for the next cycle
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_wdata;
        if (mem_read) mem_rdata <= mem[mem_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic clear_obs();
        rd_cyc = 0; wr_cyc = 0; done_cyc = 0; done_last = 0; mis_cyc = 0;
        rd_cnt = 0; wr_cnt = 0; both_cnt = 0;
        seen_wdata = '0; seen_waddr = '0; seen_raddr = '0; seen_rdata = '0;
    endtask

    task automatic sample(input int c);
        if (mem_read) begin
            rd_cnt++;
            if (rd_cyc == 0) begin
                rd_cyc     = c;
                seen_raddr = 32'(mem_addr);
            end
        end
        if (mem_write) begin
            wr_cnt++;
            wr_cyc     = c;
            seen_wdata = mem_wdata;
            seen_waddr = 32'(mem_addr);
        end
        if (mem_read && mem_write) both_cnt++;
        if (misalign && mis_cyc == 0) mis_cyc = c;
        if (done) begin
            if (done_cyc == 0) done_cyc = c;
            done_last  = c;
            seen_rdata = rdata;
        end
    endtask

    task automatic drive(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wd);
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        req_addr   = addr;
        req_wdata  = wd;
    endtask

    task automatic run_req(input logic wr, input logic [1:0] sz, input logic sg,
                           input logic [31:0] addr, input logic [31:0] wd);
        clear_obs();
        @(negedge clk);
        drive(wr, sz, sg, addr, wd);
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            sample(c);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ready", 32'(req_ready), 32'd1);
        check_eq("rst_pulses", {28'h0, done, misalign, mem_read, mem_write}, 32'h0);
        check_eq("rst_rdata", rdata, 32'h0);
        check_eq("rst_mem_addr", 32'(mem_addr), 32'h0);
        check_eq("rst_mem_wdata", mem_wdata, 32'h0);
        rst_n = 1'b1;

        // Word store then load
        run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
        check_eq("sw_wr_cyc", wr_cyc, 1);
        check_eq("sw_addr", seen_waddr, 32'd4);
        check_eq("sw_wdata", seen_wdata, 32'hDEAD_BEEF);
        check_eq("sw_done_cyc", done_cyc, 2);
        check_eq("sw_no_read", rd_cnt, 0);
        run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        check_eq("lw_rd_cyc", rd_cyc, 1);
        check_eq("lw_done_cyc", done_cyc, 3);
        check_eq("lw_rdata", seen_rdata, 32'hDEAD_BEEF);

        // Sign/zero extension from word 0x80F17F00 at index 0
        run_req(1'b1, 2'b10, 1'b0, 32'h0, 32'h80F1_7F00);
        run_req(1'b0, 2'b00, 1'b1, 32'h3, 32'h0);
        check_eq("lb3", seen_rdata, 32'hFFFF_FF80);
        check_eq("lb_done_cyc", done_cyc, 3);
        run_req(1'b0, 2'b00, 1'b0, 32'h2, 32'h0);
        check_eq("lbu2", seen_rdata, 32'h0000_00F1);
        run_req(1'b0, 2'b01, 1'b1, 32'h2, 32'h0);
        check_eq("lh2", seen_rdata, 32'hFFFF_80F1);
        run_req(1'b0, 2'b01, 1'b0, 32'h0, 32'h0);
        check_eq("lhu0", seen_rdata, 32'h0000_7F00);

        // Sub-word store read-modify-write on index 1
        run_req(1'b1, 2'b10, 1'b0, 32'h4, 32'h1122_3344);
        run_req(1'b1, 2'b00, 1'b0, 32'h5, 32'h1234_56AA);
        check_eq("sb_rd_cyc", rd_cyc, 1);
        check_eq("sb_wr_cyc", wr_cyc, 3);
        check_eq("sb_wdata", seen_wdata, 32'h1122_AA44);
        check_eq("sb_done_cyc", done_cyc, 4);
        run_req(1'b1, 2'b01, 1'b0, 32'h6, 32'hFFFF_BEEF);
        check_eq("sh_wdata", seen_wdata, 32'hBEEF_AA44);
        check_eq("sh_waddr", seen_waddr, 32'd1);
        check_eq("sh_done_cyc", done_cyc, 4);
        check_eq("rdata_hold", rdata, 32'h0000_7F00);
        check_eq("sh_overlap", both_cnt, 0);

        // Misaligned word load
        run_req(1'b0, 2'b10, 1'b0, 32'h6, 32'h0);
`ifdef LSU_MISALIGN_CHECK_EN
        check_eq("mis_pulse_cyc", mis_cyc, 1);
        check_eq("mis_strobes", rd_cnt + wr_cnt, 0);
        check_eq("mis_no_done", done_cyc, 0);
`else
        check_eq("mis_none", mis_cyc, 0);
        check_eq("mis_rd_addr", seen_raddr, 32'd1);
        check_eq("mis_done_cyc", done_cyc, 3);
        check_eq("mis_rdata", seen_rdata, 32'hBEEF_AA44);
`endif

        // Address wrap modulo MEM_WORDS
        run_req(1'b1, 2'b10, 1'b0, 32'h80, 32'h0BAD_F00D);
        check_eq("wrap_addr", seen_waddr, 32'd0);
        run_req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        check_eq("wrap_rdata", seen_rdata, 32'h0BAD_F00D);

        // Back-to-back: valid held high across two requests
        clear_obs();
        @(negedge clk);
        drive(1'b1, 2'b10, 1'b0, 32'h8, 32'h0000_0055);
        req_valid = 1'b1;
        @(posedge clk);
        #1 drive(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            sample(c);
            if (c == 4) req_valid = 1'b0;
        end
        check_eq("b2b_done1", done_cyc, 2);
        check_eq("b2b_rd_cyc", rd_cyc, 4);
        check_eq("b2b_done2", done_last, 6);
        check_eq("b2b_rdata", seen_rdata, 32'h0000_0055);
        check_eq("b2b_overlap", both_cnt, 0);

        // Reset during a sub-word store, before its write strobe
        clear_obs();
        @(negedge clk);
        drive(1'b1, 2'b00, 1'b0, 32'h8, 32'h0000_00CC);
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            sample(c);
            if (c == 2) rst_n = 1'b0;
            if (c == 3) begin
                check_eq("rmid_ready", 32'(req_ready), 32'd1);
                check_eq("rmid_strobes", {30'h0, mem_read, mem_write}, 32'h0);
            end
        end
        check_eq("rmid_no_write", wr_cnt, 0);
        check_eq("rmid_no_done", done_cyc, 0);
        rst_n = 1'b1;
        run_req(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
        check_eq("rmid_mem_kept", seen_rdata, 32'h0000_0055);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Safety net against a stalled run
    initial begin
        #200000;
        $display("FAIL timeout: got stalled run expected completion");
        $fatal(1);
    end

endmodule
